// File: rtl/event_normalizer.sv
// Event normalizer: turns raw DVS sensor events into GRAPH_SIZE-grid events
// for the graph builder, tracking time windows and dropping late events.

package graph_pkg;

  localparam int GRAPH_SIZE      = 128;
  localparam int TIME_WINDOW     = 100000;
  localparam int GRAPH_BIT_WIDTH = $clog2(GRAPH_SIZE);

  typedef struct packed {
    logic [GRAPH_BIT_WIDTH-1:0] x;
    logic [GRAPH_BIT_WIDTH-1:0] y;
    logic [GRAPH_BIT_WIDTH-1:0] t;
    logic                       p;
    logic                       valid;
  } event_type;

endpackage

module event_normalizer
  import graph_pkg::*;
#(
  parameter int     SENSOR_W      = 240,
  parameter int     SENSOR_H      = 180,
  parameter int     SENSOR_X_BITS = $clog2(SENSOR_W),
  parameter int     SENSOR_Y_BITS = $clog2(SENSOR_H),
  parameter longint X_MUL         = (longint'(GRAPH_SIZE) * 65536) / SENSOR_W,
  parameter longint Y_MUL         = (longint'(GRAPH_SIZE) * 65536) / SENSOR_H,
  parameter longint T_MUL         = (longint'(GRAPH_SIZE) << 24) / TIME_WINDOW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SENSOR_X_BITS-1:0] s_x,
  input  logic [SENSOR_Y_BITS-1:0] s_y,
  input  logic [31:0]              s_ts,
  input  logic                     s_p,
  input  logic                     s_valid,
  output logic                     s_ready,
  output event_type                m_event,
  input  logic                     m_ready,
  output logic                     window_done,
  output logic [15:0]              drop_cnt
);

  localparam logic [63:0] XMulU     = 64'(X_MUL);
  localparam logic [63:0] YMulU     = 64'(Y_MUL);
  localparam logic [63:0] TMulU     = 64'(T_MUL);
  localparam logic [31:0] WindowLen = 32'(TIME_WINDOW);
  localparam logic [63:0] MaxCoordW = 64'(GRAPH_SIZE - 1);
  localparam logic [GRAPH_BIT_WIDTH-1:0] MaxCoord = GRAPH_BIT_WIDTH'(GRAPH_SIZE - 1);

  // Saturate a scaled coordinate to the last grid cell.
  function automatic logic [GRAPH_BIT_WIDTH-1:0] clampCoord(input logic [63:0] v);
    if (v > MaxCoordW) begin
      clampCoord = MaxCoord;
    end else begin
      clampCoord = v[GRAPH_BIT_WIDTH-1:0];
    end
  endfunction

  // Window tracking state
  logic        armed_q, armed_d;
  logic [31:0] winStart_q, winStart_d;
  logic [15:0] dropCnt_q, dropCnt_d;

  // Stage 1: raw event plus its time offset inside the window
  logic                     s1Valid_q, s1Valid_d;
  logic [SENSOR_X_BITS-1:0] s1X_q, s1X_d;
  logic [SENSOR_Y_BITS-1:0] s1Y_q, s1Y_d;
  logic                     s1P_q, s1P_d;
  logic [31:0]              s1TRel_q, s1TRel_d;
  logic                     s1NewWin_q, s1NewWin_d;

  // Stage 2: scaled event; pending marks the one-cycle bubble after window_done
  logic      s2Full_q, s2Full_d;
  logic      s2Pend_q, s2Pend_d;
  event_type s2Event_q, s2Event_d;
  logic      windowDone_q, windowDone_d;

  logic        mValid;
  logic        s2Adv;
  logic        accept;
  logic        lateEvent;
  logic        newWindow;
  logic [31:0] tRelRaw;
  logic [63:0] xProd;
  logic [63:0] yProd;
  logic [63:0] tProd;

  // Handshake: S2 can take a new event when empty or when its event leaves
  // this cycle; a pending (bubble) event blocks S2 until it becomes visible.
  always_comb begin
    mValid  = s2Full_q && !s2Pend_q;
    s2Adv   = !s2Full_q || (mValid && m_ready);
    s_ready = !rst && (!s1Valid_q || s2Adv);
    accept  = s_valid && s_ready;
  end

  // Window decision on the incoming event: arm, drop late events, or restart
  // the window when the offset reaches TIME_WINDOW.
  always_comb begin
    tRelRaw    = s_ts - winStart_q;
    lateEvent  = armed_q && (s_ts < winStart_q);
    newWindow  = armed_q && !lateEvent && (tRelRaw >= WindowLen);
    armed_d    = armed_q;
    winStart_d = winStart_q;
    dropCnt_d  = dropCnt_q;
    if (accept) begin
      if (!armed_q) begin
        armed_d    = 1'b1;
        winStart_d = s_ts;
      end else if (lateEvent) begin
        if (dropCnt_q != 16'hFFFF) begin
          dropCnt_d = dropCnt_q + 16'd1;
        end
      end else if (newWindow) begin
        winStart_d = s_ts;
      end
    end
  end

  // Stage 1 next state: load accepted in-order events, otherwise drain into S2.
  always_comb begin
    s1Valid_d  = s1Valid_q && !s2Adv;
    s1X_d      = s1X_q;
    s1Y_d      = s1Y_q;
    s1P_d      = s1P_q;
    s1TRel_d   = s1TRel_q;
    s1NewWin_d = s1NewWin_q;
    if (accept && !lateEvent) begin
      s1Valid_d  = 1'b1;
      s1X_d      = s_x;
      s1Y_d      = s_y;
      s1P_d      = s_p;
      s1TRel_d   = (!armed_q || newWindow) ? 32'd0 : tRelRaw;
      s1NewWin_d = newWindow;
    end
  end

  // Fixed-point scaling of the stage-1 event onto the graph grid.
  always_comb begin
    xProd = 64'(s1X_q) * XMulU;
    yProd = 64'(s1Y_q) * YMulU;
    tProd = 64'(s1TRel_q) * TMulU;
  end

  // Stage 2 next state: a window-opening event raises window_done on entry
  // and stays hidden for one cycle so the pulse precedes it downstream.
  always_comb begin
    s2Full_d     = s2Full_q;
    s2Pend_d     = s2Pend_q;
    s2Event_d    = s2Event_q;
    windowDone_d = 1'b0;
    if (s2Pend_q) begin
      s2Pend_d = 1'b0;
    end else if (s2Adv) begin
      s2Full_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Event_d.x     = clampCoord(xProd >> 16);
        s2Event_d.y     = clampCoord(yProd >> 16);
        s2Event_d.t     = clampCoord(tProd >> 24);
        s2Event_d.p     = s1P_q;
        s2Event_d.valid = 1'b0;
        s2Pend_d        = s1NewWin_q;
        windowDone_d    = s1NewWin_q;
      end
    end
  end

  // Window tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      winStart_q <= 32'd0;
      dropCnt_q  <= 16'd0;
    end else begin
      armed_q    <= armed_d;
      winStart_q <= winStart_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1X_q      <= '0;
      s1Y_q      <= '0;
      s1P_q      <= 1'b0;
      s1TRel_q   <= 32'd0;
      s1NewWin_q <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1X_q      <= s1X_d;
      s1Y_q      <= s1Y_d;
      s1P_q      <= s1P_d;
      s1TRel_q   <= s1TRel_d;
      s1NewWin_q <= s1NewWin_d;
    end
  end

  // Stage 2 registers and the window_done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Full_q     <= 1'b0;
      s2Pend_q     <= 1'b0;
      s2Event_q    <= '0;
      windowDone_q <= 1'b0;
    end else begin
      s2Full_q     <= s2Full_d;
      s2Pend_q     <= s2Pend_d;
      s2Event_q    <= s2Event_d;
      windowDone_q <= windowDone_d;
    end
  end

  // Output view of stage 2 with the live valid flag
  always_comb begin
    m_event       = s2Event_q;
    m_event.valid = mValid;
  end

  assign window_done = windowDone_q;
  assign drop_cnt    = dropCnt_q;

endmodule

// File: tb/tb_event_normalizer.sv
// Testbench for event_normalizer: directed steps plus a random stream,
// checked against a window/scaling model built from plain arithmetic.

module tb_event_normalizer;
  import graph_pkg::*;

  localparam longint XM = (128 * 65536) / 240;
  localparam longint YM = (128 * 65536) / 180;
  localparam longint TM = (longint'(128) << 24) / 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_x;
  logic [7:0]  s_y;
  logic [31:0] s_ts;
  logic        s_p;
  logic        s_valid;
  logic        s_ready;
  event_type   m_event;
  logic        m_ready;
  logic        window_done;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  event_normalizer dut (
    .clk(clk), .rst(rst), .s_x(s_x), .s_y(s_y), .s_ts(s_ts), .s_p(s_p),
    .s_valid(s_valid), .s_ready(s_ready), .m_event(m_event), .m_ready(m_ready),
    .window_done(window_done), .drop_cnt(drop_cnt)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    event_type ev;
    bit        nw;
  } exp_t;

  exp_t        expQ[$];
  bit          mArmed = 0;
  longint      mWin = 0;
  int          mDrops = 0;
  int          mWdExp = 0;
  int          wdSeen = 0;
  bit          wdPending = 0;
  bit          wdPrev = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint clampC(input longint v);
    return (v > 127) ? 127 : v;
  endfunction

  function automatic event_type mkEvent(input int x, input int y, input longint trel, input bit p);
    event_type e;
    e.x     = 7'(clampC((longint'(x) * XM) / 65536));
    e.y     = 7'(clampC((longint'(y) * YM) / 65536));
    e.t     = 7'(clampC((trel * TM) / 16777216));
    e.p     = p;
    e.valid = 1'b1;
    return e;
  endfunction

  // Reference window model applied to every accepted input event
  function void modelAccept(input int x, input int y, input longint ts, input bit p);
    exp_t   item;
    longint rel;
    if (!mArmed) begin
      mArmed  = 1;
      mWin    = ts;
      item.ev = mkEvent(x, y, 0, p);
      item.nw = 0;
      expQ.push_back(item);
    end else if (ts < mWin) begin
      mDrops++;
    end else begin
      rel     = ts - mWin;
      item.nw = 0;
      if (rel >= 100000) begin
        mWin    = ts;
        rel     = 0;
        item.nw = 1;
        mWdExp++;
      end
      item.ev = mkEvent(x, y, rel, p);
      expQ.push_back(item);
    end
  endfunction

  // Output monitor: every transfer must match the model queue in order and
  // every window-opening event must be preceded by a window_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (window_done) begin
        checkOutput("wd_single_cycle", 64'(wdPrev), 64'd0);
        wdSeen++;
        wdPending = 1;
      end
      wdPrev = window_done;
      if (m_event.valid && m_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", 64'(m_event), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_stream", 64'(m_event), 64'(e.ev));
          if (e.nw) begin
            checkOutput("wd_before_new_window", 64'(wdPending), 64'd1);
            wdPending = 0;
          end
        end
      end
    end else begin
      wdPrev = 0;
    end
  end

  // One cycle of input drive; called and returns at posedge+1
  task automatic streamCycle(input bit v, input logic [7:0] x, input logic [7:0] y,
                             input logic [31:0] ts, input logic p, output bit took);
    s_valid = v;
    s_x     = x;
    s_y     = y;
    s_ts    = ts;
    s_p     = p;
    @(negedge clk);
    took = s_valid && s_ready;
    if (took) modelAccept(int'(x), int'(y), longint'(ts), p);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                               input logic [31:0] ts, input logic p);
    bit took = 0;
    for (int i = 0; i < 50 && !took; i++) streamCycle(1'b1, x, y, ts, p, took);
    if (!took) checkOutput("accept_timeout", 64'(took), 64'd1);
    s_valid = 1'b0;
  endtask

  // Expect the last applied event two edges after acceptance, no window_done
  task automatic expectAfter(input string tag, input event_type e);
    @(negedge clk);
    checkOutput({tag, "_early"}, 64'(m_event.valid), 64'd0);
    @(negedge clk);
    checkOutput(tag, 64'(m_event), 64'(e));
    checkOutput({tag, "_wd"}, 64'(window_done), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(tag, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    event_type   e;
    bit          took;
    int          idx;
    int          n;
    logic [31:0] curTs;
    logic [31:0] bpTs[4];
    logic [7:0]  rx, ry;
    logic [31:0] rts;
    logic        rp;
    bit          haveEv;

    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_x = '0; s_y = '0; s_ts = '0; s_p = 1'b0;
    #2 rst = 1'b1;

    // Reset values
    @(negedge clk);
    checkOutput("reset_m_event", 64'(m_event), 64'd0);
    checkOutput("reset_wd", 64'(window_done), 64'd0);
    checkOutput("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("reset_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("s_ready_after_reset", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;

    // First event arms the window
    applyStimulus(8'd239, 8'd90, 32'd1000, 1'b1);
    e = '{x: 7'd127, y: 7'd63, t: 7'd0, p: 1'b1, valid: 1'b1};
    expectAfter("first_event", e);

    // In-window events and the top of the time axis
    applyStimulus(8'd120, 8'd0, 32'd51000, 1'b0);
    e = '{x: 7'd63, y: 7'd0, t: 7'd63, p: 1'b0, valid: 1'b1};
    expectAfter("mid_window", e);
    applyStimulus(8'd5, 8'd5, 32'd100999, 1'b1);
    e = '{x: 7'd2, y: 7'd3, t: 7'd127, p: 1'b1, valid: 1'b1};
    expectAfter("window_end", e);

    // Window boundary: pulse first, event one cycle later with t = 0
    applyStimulus(8'd10, 8'd20, 32'd101000, 1'b0);
    @(negedge clk);
    checkOutput("boundary_wd_early", 64'(window_done), 64'd0);
    @(negedge clk);
    checkOutput("boundary_wd_pulse", 64'(window_done), 64'd1);
    checkOutput("boundary_bubble", 64'(m_event.valid), 64'd0);
    @(negedge clk);
    checkOutput("boundary_wd_clear", 64'(window_done), 64'd0);
    e = '{x: 7'd5, y: 7'd14, t: 7'd0, p: 1'b0, valid: 1'b1};
    checkOutput("boundary_event", 64'(m_event), 64'(e));
    @(posedge clk); #1;

    // Out-of-order event is dropped, next in-order one passes
    applyStimulus(8'd1, 8'd1, 32'd500, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drop_cnt_one", 64'(drop_cnt), 64'd1);
    applyStimulus(8'd30, 8'd40, 32'd101500, 1'b1);
    e = '{x: 7'd15, y: 7'd28, t: 7'd0, p: 1'b1, valid: 1'b1};
    expectAfter("after_drop", e);

    // Backpressure: 5 stalled cycles with 4 back-to-back events
    bpTs[0] = 32'd101600; bpTs[1] = 32'd101601; bpTs[2] = 32'd101602; bpTs[3] = 32'd101603;
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      streamCycle(1'b1, 8'(idx * 50), 8'(idx * 40), bpTs[idx], 1'(idx), took);
      if (took) idx++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    @(negedge clk);
    checkOutput("bp_s_ready_low", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      streamCycle(1'b1, 8'(idx * 50), 8'(idx * 40), bpTs[idx], 1'(idx), took);
      if (took) idx++;
      n++;
    end
    checkOutput("bp_all_accepted", 64'(idx), 64'd4);
    drain("bp_drained");

    // Random stream with gaps, stalls, late events and window jumps
    curTs  = 32'd300000;
    haveEv = 0;
    rx = '0; ry = '0; rts = '0; rp = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!haveEv) begin
        n = int'($urandom_range(0, 99));
        if (n < 8) rts = curTs - $urandom_range(1, 5000);
        else if (n < 16) begin curTs = curTs + $urandom_range(100000, 250000); rts = curTs; end
        else begin curTs = curTs + $urandom_range(0, 3000); rts = curTs; end
        rx = 8'($urandom_range(0, 255));
        ry = 8'($urandom_range(0, 255));
        rp = 1'($urandom_range(0, 1));
        haveEv = 1;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      streamCycle(($urandom_range(0, 3) != 0), rx, ry, rts, rp, took);
      if (took) haveEv = 0;
    end
    drain("random_drained");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("random_drop_cnt", 64'(drop_cnt), 64'(mDrops));
    checkOutput("random_wd_count", 64'(wdSeen), 64'(mWdExp));

    // Reset with two events in flight
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 2; c++) begin
      streamCycle(1'b1, 8'd9, 8'd9, curTs + 32'(c), 1'b0, took);
      if (took) idx++;
    end
    s_valid = 1'b0;
    checkOutput("inflight_two", 64'(idx), 64'd2);
    rst = 1'b1;
    expQ.delete();
    mArmed = 0; mDrops = 0; wdPending = 0;
    @(negedge clk);
    checkOutput("midreset_m_event", 64'(m_event), 64'd0);
    checkOutput("midreset_wd", 64'(window_done), 64'd0);
    checkOutput("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    applyStimulus(8'd100, 8'd100, 32'd7, 1'b0);
    e = '{x: 7'd53, y: 7'd71, t: 7'd0, p: 1'b0, valid: 1'b1};
    expectAfter("rearm_event", e);
    drain("final_drained");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
